// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared types and constants for the UDP deframer
package udp_pkg;

    localparam int          AXIS_BYTES    = 4;
    localparam logic [7:0]  UDP_PROTOCOL  = 8'd17;
    localparam logic [15:0] UDP_HDR_BYTES = 16'd8;

    typedef enum logic [1:0] {
        HDR0,
        HDR1,
        PAYLOAD,
        DROP
    } state_e;

    // Network byte order on the wire: first lane is the high byte.
    function automatic logic [15:0] be16(input logic [15:0] bytes);
        return {bytes[7:0], bytes[15:8]};
    endfunction

endpackage

// File: rtl/udp_deframer.sv
// rtl/udp_deframer.sv - strips the UDP header, trims payload to UDP length
module udp_deframer
    import udp_pkg::*;
(
    input  logic        clk,
    input  logic        areset,
    input  logic        axis_i_tvalid,
    output logic        axis_i_tready,
    input  logic        axis_i_tlast,
    input  logic [31:0] axis_i_tdata,
    input  logic [15:0] axis_i_length,
    input  logic [7:0]  axis_i_protocol,
    input  logic [31:0] axis_i_src_ip,
    input  logic [31:0] axis_i_dst_ip,
    output logic        axis_o_tvalid,
    input  logic        axis_o_tready,
    output logic        axis_o_tlast,
    output logic [31:0] axis_o_tdata,
    output logic [15:0] axis_o_length,
    output logic [15:0] axis_o_src_port,
    output logic [15:0] axis_o_dst_port,
    output logic [31:0] axis_o_src_ip,
    output logic [31:0] axis_o_dst_ip,
    output logic        err_pulse
);

    state_e      state_q;
    logic [15:0] remaining_q;
    logic [15:0] length_q;
    logic [15:0] src_port_q;
    logic [15:0] dst_port_q;
    logic [31:0] src_ip_q;
    logic [31:0] dst_ip_q;
    logic        err_q;

    logic        in_beat;
    logic        in_payload;
    logic        rem_le4;
    logic [15:0] udp_len;

    assign in_payload = (state_q == PAYLOAD);
    assign rem_le4    = (remaining_q <= 16'd4);
    assign udp_len    = be16(axis_i_tdata[15:0]);

    // Only the payload state is subject to downstream backpressure.
    assign axis_i_tready = in_payload ? axis_o_tready : 1'b1;
    assign in_beat       = axis_i_tvalid & axis_i_tready;

    assign axis_o_tvalid   = in_payload & axis_i_tvalid;
    assign axis_o_tlast    = in_payload & (axis_i_tlast | rem_le4);
    assign axis_o_tdata    = axis_i_tdata;
    assign axis_o_length   = length_q;
    assign axis_o_src_port = src_port_q;
    assign axis_o_dst_port = dst_port_q;
    assign axis_o_src_ip   = src_ip_q;
    assign axis_o_dst_ip   = dst_ip_q;
    assign err_pulse       = err_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= HDR0;
            remaining_q <= '0;
            length_q    <= '0;
            src_port_q  <= '0;
            dst_port_q  <= '0;
            src_ip_q    <= '0;
            dst_ip_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                HDR0: begin
                    if (in_beat) begin
                        src_port_q <= be16(axis_i_tdata[15:0]);
                        dst_port_q <= be16(axis_i_tdata[31:16]);
                        src_ip_q   <= axis_i_src_ip;
                        dst_ip_q   <= axis_i_dst_ip;
                        // A one-beat non-UDP frame is legal; a one-beat UDP frame is truncated.
                        if (axis_i_tlast) begin
                            state_q <= HDR0;
                            err_q   <= (axis_i_protocol == UDP_PROTOCOL);
                        end else if (axis_i_protocol != UDP_PROTOCOL) begin
                            state_q <= DROP;
                        end else begin
                            state_q <= HDR1;
                        end
                    end
                end
                HDR1: begin
                    if (in_beat) begin
                        if (axis_i_tlast) begin
                            state_q <= HDR0;
                            err_q   <= 1'b1;
                        end else if ((udp_len < UDP_HDR_BYTES) || (udp_len > axis_i_length)) begin
                            state_q <= DROP;
                            err_q   <= 1'b1;
                        end else if (udp_len == UDP_HDR_BYTES) begin
                            state_q <= DROP;
                        end else begin
                            remaining_q <= udp_len - UDP_HDR_BYTES;
                            length_q    <= udp_len - UDP_HDR_BYTES;
                            state_q     <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (in_beat) begin
                        remaining_q <= rem_le4 ? 16'd0 : (remaining_q - 16'd4);
                        // Input ending early is a runt; datagram ending early leaves padding to drop.
                        if (axis_i_tlast) begin
                            state_q <= HDR0;
                            err_q   <= ~rem_le4;
                        end else if (rem_le4) begin
                            state_q <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (in_beat && axis_i_tlast) begin
                        state_q <= HDR0;
                    end
                end
                default: state_q <= HDR0;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_deframer.sv
// tb/tb_udp_deframer.sv - randomized self-checking bench for udp_deframer
module tb_udp_deframer;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        axis_i_tvalid = 1'b0;
    logic        axis_i_tready;
    logic        axis_i_tlast = 1'b0;
    logic [31:0] axis_i_tdata = '0;
    logic [15:0] axis_i_length = '0;
    logic [7:0]  axis_i_protocol = '0;
    logic [31:0] axis_i_src_ip = '0;
    logic [31:0] axis_i_dst_ip = '0;
    logic        axis_o_tvalid;
    logic        axis_o_tready = 1'b1;
    logic        axis_o_tlast;
    logic [31:0] axis_o_tdata;
    logic [15:0] axis_o_length;
    logic [15:0] axis_o_src_port;
    logic [15:0] axis_o_dst_port;
    logic [31:0] axis_o_src_ip;
    logic [31:0] axis_o_dst_ip;
    logic        err_pulse;

    udp_deframer dut (
        .clk            (clk),
        .areset         (areset),
        .axis_i_tvalid  (axis_i_tvalid),
        .axis_i_tready  (axis_i_tready),
        .axis_i_tlast   (axis_i_tlast),
        .axis_i_tdata   (axis_i_tdata),
        .axis_i_length  (axis_i_length),
        .axis_i_protocol(axis_i_protocol),
        .axis_i_src_ip  (axis_i_src_ip),
        .axis_i_dst_ip  (axis_i_dst_ip),
        .axis_o_tvalid  (axis_o_tvalid),
        .axis_o_tready  (axis_o_tready),
        .axis_o_tlast   (axis_o_tlast),
        .axis_o_tdata   (axis_o_tdata),
        .axis_o_length  (axis_o_length),
        .axis_o_src_port(axis_o_src_port),
        .axis_o_dst_port(axis_o_dst_port),
        .axis_o_src_ip  (axis_o_src_ip),
        .axis_o_dst_ip  (axis_o_dst_ip),
        .err_pulse      (err_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic [15:0] len;
        logic [15:0] sp;
        logic [15:0] dp;
        logic [31:0] si;
        logic [31:0] di;
    } beat_t;

    beat_t       expq[$];
    beat_t       mb;
    logic [31:0] fw[$];
    int          checks = 0;
    int          errors = 0;
    int          err_seen = 0;
    int          out_beats = 0;
    int          err_exp = 0;
    int          stalls = 0;
    logic        rnd_rdy = 1'b0;
    logic        fix_rdy = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            axis_o_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : fix_rdy;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!areset) begin
                if (err_pulse) err_seen++;
                if (axis_o_tvalid && axis_o_tready) begin
                    out_beats++;
                    if (expq.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        mb = expq.pop_front();
                        check("data", axis_o_tdata, mb.d);
                        check("tlast", axis_o_tlast, mb.l);
                        check("length", axis_o_length, mb.len);
                        check("src_port", axis_o_src_port, mb.sp);
                        check("dst_port", axis_o_dst_port, mb.dp);
                        check("src_ip", axis_o_src_ip, mb.si);
                        check("dst_ip", axis_o_dst_ip, mb.di);
                    end
                end
            end
        end
    end

    // Expected outcome of one datagram, straight from the framing rules.
    task automatic model(input logic [7:0] proto, input logic [15:0] iplen);
        int nb, pay, need, avail, n;
        logic [15:0] sp, dp, ul;
        beat_t b;
        nb = fw.size();
        sp = {fw[0][7:0], fw[0][15:8]};
        dp = {fw[0][23:16], fw[0][31:24]};
        if (nb == 1) begin
            if (proto == 8'd17) err_exp++;
            return;
        end
        if (proto != 8'd17) return;
        if (nb == 2) begin
            err_exp++;
            return;
        end
        ul = {fw[1][7:0], fw[1][15:8]};
        if (ul < 16'd8 || ul > iplen) begin
            err_exp++;
            return;
        end
        if (ul == 16'd8) return;
        pay   = int'(ul) - 8;
        need  = (pay + 3) / 4;
        avail = nb - 2;
        n     = (avail < need) ? avail : need;
        if (avail < need) err_exp++;
        for (int k = 0; k < n; k++) begin
            b.d = fw[2 + k]; b.l = (k == n - 1); b.len = 16'(pay);
            b.sp = sp; b.dp = dp; b.si = axis_i_src_ip; b.di = axis_i_dst_ip;
            expq.push_back(b);
        end
    endtask

    task automatic build(input logic [15:0] sp, input logic [15:0] dp,
                         input logic [15:0] ul, input int nb);
        fw.delete();
        fw.push_back({dp[7:0], dp[15:8], sp[7:0], sp[15:8]});
        if (nb > 1) fw.push_back({16'($urandom), ul[7:0], ul[15:8]});
        for (int i = 2; i < nb; i++) fw.push_back($urandom);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        int n;
        logic acc;
        n = 0;
        acc = 1'b0;
        axis_i_tvalid = 1'b1;
        axis_i_tdata  = d;
        axis_i_tlast  = last;
        while (!acc) begin
            @(negedge clk);
            acc = axis_i_tready;
            if (!acc) stalls++;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 2000) begin
                check("stall_timeout", 0, 1);
                acc = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] proto, input logic [15:0] iplen);
        axis_i_protocol = proto;
        axis_i_length   = iplen;
        axis_i_src_ip   = $urandom;
        axis_i_dst_ip   = $urandom;
        model(proto, iplen);
        for (int i = 0; i < fw.size(); i++) begin
            send_beat(fw[i], i == fw.size() - 1);
            if (rnd_rdy && $urandom_range(0, 3) == 0) begin
                axis_i_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        axis_i_tvalid = 1'b0;
        axis_i_tlast  = 1'b0;
    endtask

    task automatic phase_end(input string tag, input int exp_beats, input int base_beats,
                             input int base_err);
        repeat (3) @(posedge clk);
        #1;
        if (exp_beats >= 0) check({tag, "_beats"}, out_beats - base_beats, exp_beats);
        check({tag, "_errs"}, err_seen - base_err, err_exp);
        check({tag, "_pending"}, expq.size(), 0);
        err_exp = 0;
    endtask

    int bb, be;
    logic [7:0]  rp;
    logic [15:0] ril, rul;
    int rnb, rsel;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", axis_i_tready, 1);
        check("rst_out_valid", axis_o_tvalid, 0);
        check("rst_err", err_pulse, 0);
        check("rst_length", axis_o_length, 0);
        check("rst_ports", {axis_o_src_port, axis_o_dst_port}, 0);
        check("rst_ips", {axis_o_src_ip, axis_o_dst_ip}, 0);
        areset = 1'b0;
        @(posedge clk);
        #1;

        bb = out_beats; be = err_seen;
        build(16'h1234, 16'h0050, 16'd20, 5);
        send_frame(8'd17, 16'd20);
        phase_end("basic", 3, bb, be);

        bb = out_beats; be = err_seen;
        build(16'h0400, 16'h0401, 16'd13, 12);
        send_frame(8'd17, 16'd46);
        phase_end("padded", 2, bb, be);
        bb = out_beats; be = err_seen;
        build(16'hbeef, 16'h0035, 16'd20, 5);
        send_frame(8'd17, 16'd20);
        phase_end("after_pad", 3, bb, be);

        bb = out_beats; be = err_seen;
        fix_rdy = 1'b0;
        stalls = 0;
        build(16'h0016, 16'h9000, 16'd30, 10);
        send_frame(8'd6, 16'd40);
        check("tcp_no_stall", stalls, 0);
        fix_rdy = 1'b1;
        phase_end("tcp", 0, bb, be);
        bb = out_beats; be = err_seen;
        build(16'h1111, 16'h2222, 16'd17, 5);
        send_frame(8'd17, 16'd20);
        phase_end("after_tcp", 3, bb, be);

        bb = out_beats; be = err_seen;
        build(16'h0001, 16'h0002, 16'd40, 5);
        send_frame(8'd17, 16'd20);
        phase_end("len_big", 0, bb, be);
        check("len_big_err1", err_seen - be, 1);
        bb = out_beats; be = err_seen;
        build(16'h0001, 16'h0002, 16'd5, 5);
        send_frame(8'd17, 16'd20);
        phase_end("len_small", 0, bb, be);
        check("len_small_err1", err_seen - be, 1);

        bb = out_beats; be = err_seen;
        build(16'h0007, 16'h0008, 16'd24, 4);
        send_frame(8'd17, 16'd24);
        phase_end("runt", 2, bb, be);
        check("runt_err1", err_seen - be, 1);

        rnd_rdy = 1'b1;
        bb = out_beats; be = err_seen;
        for (int f = 0; f < 1000; f++) begin
            rp   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 16)) : 8'd17;
            ril  = 16'($urandom_range(4, 48));
            rnb  = (int'(ril) + 3) / 4;
            if ($urandom_range(0, 7) == 0) rnb = $urandom_range(1, rnb);
            rsel = $urandom_range(0, 9);
            if (rsel == 0)      rul = 16'($urandom_range(0, 7));
            else if (rsel == 1) rul = ril + 16'($urandom_range(1, 20));
            else if (rsel == 2) rul = 16'd8;
            else                rul = (ril >= 16'd8) ? 16'($urandom_range(8, int'(ril))) : 16'd8;
            build(16'($urandom), 16'($urandom), rul, rnb);
            send_frame(rp, ril);
        end
        rnd_rdy = 1'b0;
        fix_rdy = 1'b0;
        phase_end("random", -1, bb, be);

        build(16'h5555, 16'h6666, 16'd20, 5);
        axis_i_protocol = 8'd17;
        axis_i_length   = 16'd20;
        axis_i_src_ip   = 32'hc0a80001;
        axis_i_dst_ip   = 32'hc0a80002;
        send_beat(fw[0], 1'b0);
        send_beat(fw[1], 1'b0);
        axis_i_tdata = fw[2];
        @(negedge clk);
        check("mid_valid", axis_o_tvalid, 1);
        check("mid_length", axis_o_length, 12);
        areset = 1'b1;
        #1;
        check("mid_rst_valid", axis_o_tvalid, 0);
        check("mid_rst_ready", axis_i_tready, 1);
        check("mid_rst_length", axis_o_length, 0);
        check("mid_rst_ports", {axis_o_src_port, axis_o_dst_port}, 0);
        check("mid_rst_ips", {axis_o_src_ip, axis_o_dst_ip}, 0);
        check("mid_rst_err", err_pulse, 0);
        axis_i_tvalid = 1'b0;
        @(posedge clk);
        #1;
        areset = 1'b0;
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
